// File: rtl/seq_loader_if.sv
// seq_loader_if: byte-stream input and coded-array output handshake bundle for seq_loader
interface seq_loader_if #(parameter int LEN = 7);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic [0:LEN][0:1] codedA;
   logic [0:LEN][0:1] codedB;
   logic [0:LEN][0:1] codedC;
   logic              out_valid;
   logic              out_ack;
   logic              err;
   logic              busy;

   modport master (
      output in_data, in_valid, out_ack,
      input  in_ready, codedA, codedB, codedC, out_valid, err, busy
   );

   modport slave (
      input  in_data, in_valid, out_ack,
      output in_ready, codedA, codedB, codedC, out_valid, err, busy
   );
endinterface

// File: rtl/seq_loader.sv
// seq_loader: frames '>'-prefixed ASCII A/B/C nucleotide sequences into 2-bit coded arrays; SEQ_LOADER_LOWERCASE_EN accepts lower-case bases
module seq_loader #(
   parameter int LEN = 7
) (
   input logic         CLK,
   input logic         rst,
   seq_loader_if.slave bus
);
   localparam int IW = (LEN > 0) ? $clog2(LEN + 1) : 1;
   localparam logic [IW-1:0] LAST = IW'(LEN);

   typedef enum logic [1:0] {IDLE, LOAD, HOLD, ERROR} state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic [1:0]    sel;
   logic [7:0]    ch;
   logic [1:0]    code;
   logic          is_ws, is_start, is_base, acc;

   // Byte classification; lower-case bases are folded onto upper case when enabled
   always_comb begin
      is_ws    = bus.in_data == 8'h20 || bus.in_data == 8'h0A || bus.in_data == 8'h0D;
      is_start = bus.in_data == 8'h3E;
`ifdef SEQ_LOADER_LOWERCASE_EN
      ch       = (bus.in_data inside {8'h61, 8'h63, 8'h67, 8'h74}) ? bus.in_data - 8'h20 : bus.in_data;
`else
      ch       = bus.in_data;
`endif
      is_base  = ch inside {8'h41, 8'h43, 8'h47, 8'h54};
      code     = ch == 8'h43 ? 2'b01 : ch == 8'h47 ? 2'b10 : ch == 8'h54 ? 2'b11 : 2'b00;
      acc      = bus.in_valid && bus.in_ready;
   end

   // Frame FSM with registered handshake/status outputs and the coded array storage
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         idx           <= '0;
         sel           <= '0;
         bus.codedA    <= '0;
         bus.codedB    <= '0;
         bus.codedC    <= '0;
         bus.out_valid <= 1'b0;
         bus.err       <= 1'b0;
         bus.busy      <= 1'b0;
         bus.in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE, ERROR: begin
               if (acc && is_start) begin
                  state    <= LOAD;
                  idx      <= '0;
                  sel      <= '0;
                  bus.err  <= 1'b0;
                  bus.busy <= 1'b1;
               end
            end
            LOAD: begin
               if (acc && !is_ws) begin
                  if (is_start) begin
                     idx <= '0;
                     sel <= '0;
                  end else if (is_base) begin
                     case (sel)
                        2'd0:    bus.codedA[idx] <= code;
                        2'd1:    bus.codedB[idx] <= code;
                        default: bus.codedC[idx] <= code;
                     endcase
                     if (idx == LAST) begin
                        idx <= '0;
                        if (sel == 2'd2) begin
                           state         <= HOLD;
                           sel           <= '0;
                           bus.in_ready  <= 1'b0;
                           bus.out_valid <= 1'b1;
                           bus.busy      <= 1'b0;
                        end else begin
                           sel <= sel + 2'd1;
                        end
                     end else begin
                        idx <= idx + 1'b1;
                     end
                  end else begin
                     state    <= ERROR;
                     bus.err  <= 1'b1;
                     bus.busy <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (bus.out_ack) begin
                  state         <= IDLE;
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_loader.sv
// tb_seq_loader: scoreboard bench for seq_loader framing, encoding, errors, restart and reset abort
module tb_seq_loader;
   localparam int LEN = 7;
   localparam logic [47:0] F1 = {16'b0111010010110011, 16'b0110110100111100, 16'b0101011110101101};

   logic CLK = 1'b0;
   logic rst = 1'b0;
   always #5 CLK = ~CLK;

   seq_loader_if #(.LEN(LEN)) bus();
   seq_loader #(.LEN(LEN)) dut (.CLK(CLK), .rst(rst), .bus(bus.slave));

   int          tests = 0;
   int          fails = 0;
   logic [47:0] sb[$];
   logic        prev_ov = 1'b0;

   function automatic bit model_base(input byte c);
`ifdef SEQ_LOADER_LOWERCASE_EN
      return c inside {"A", "C", "G", "T", "a", "c", "g", "t"};
`else
      return c inside {"A", "C", "G", "T"};
`endif
   endfunction

   function automatic logic [1:0] model_code(input byte c);
      if (c == "C" || c == "c") return 2'b01;
      if (c == "G" || c == "g") return 2'b10;
      if (c == "T" || c == "t") return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic [47:0] model_frame(input string s);
      logic [47:0] r = '0;
      int n = 0;
      for (int i = 0; i < s.len(); i++)
         if (model_base(s[i]) && n < 24) begin
            r[47-2*n -: 2] = model_code(s[i]);
            n++;
         end
      return r;
   endfunction

   // Scoreboard: every rising out_valid must match the oldest pushed frame
   always @(negedge CLK) begin
      logic [47:0] exp;
      logic [47:0] got;
      if (bus.out_valid && !prev_ov) begin
         tests++;
         got = {bus.codedA, bus.codedB, bus.codedC};
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL frame_unexpected: out_valid rose with arrays %h, none expected", got);
         end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
               fails++;
               $display("FAIL frame_data: got %h required %h", got, exp);
            end
         end
      end
      prev_ov = bus.out_valid;
   end

   task automatic send(input byte b);
      int w = 0;
      while (bus.in_ready !== 1'b1 && w < 50) begin
         @(negedge CLK);
         w++;
      end
      if (w == 50) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
      end
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      @(negedge CLK);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_str(input string s, input bit gaps);
      for (int i = 0; i < s.len(); i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge CLK);
         send(s[i]);
      end
   endtask

   task automatic do_ack();
      bus.out_ack = 1'b1;
      @(negedge CLK);
      bus.out_ack = 1'b0;
   endtask

   task automatic test_reset();
      tests++;
      if ({bus.out_valid, bus.err, bus.busy, bus.in_ready} !== 4'b0001) begin
         fails++;
         $display("FAIL reset_flags: ov/err/busy/rdy=%b required 0001", {bus.out_valid, bus.err, bus.busy, bus.in_ready});
      end
      tests++;
      if ({bus.codedA, bus.codedB, bus.codedC} !== 48'h0) begin
         fails++;
         $display("FAIL reset_arrays: got %h required 0", {bus.codedA, bus.codedB, bus.codedC});
      end
   endtask

   task automatic test_basic_frame();
      sb.push_back(F1);
      send_str(">CTCAGTATCGTCATTACCCTGGTC", 1'b0);
      tests++;
      if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b100) begin
         fails++;
         $display("FAIL basic_hold: ov/rdy/busy=%b required 100", {bus.out_valid, bus.in_ready, bus.busy});
      end
      bus.in_data  = "A";
      bus.in_valid = 1'b1;
      repeat (3) @(negedge CLK);
      tests++;
      if ({bus.in_ready, bus.out_valid} !== 2'b01 || {bus.codedA, bus.codedB, bus.codedC} !== F1) begin
         fails++;
         $display("FAIL basic_frozen: rdy/ov=%b arrays %h required 01 %h", {bus.in_ready, bus.out_valid}, {bus.codedA, bus.codedB, bus.codedC}, F1);
      end
      bus.in_valid = 1'b0;
      do_ack();
      tests++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01 || {bus.codedA, bus.codedB, bus.codedC} !== F1) begin
         fails++;
         $display("FAIL basic_ack: ov/rdy=%b arrays %h required 01 %h", {bus.out_valid, bus.in_ready}, {bus.codedA, bus.codedB, bus.codedC}, F1);
      end
   endtask

   task automatic test_whitespace_gaps();
      sb.push_back(F1);
      send_str(">CTCAGTAT\r\nCGTCATTA\r\nCCCTGGTC", 1'b1);
      tests++;
      if (bus.out_valid !== 1'b1) begin
         fails++;
         $display("FAIL gaps_valid: out_valid=%b required 1", bus.out_valid);
      end
      do_ack();
   endtask

   task automatic test_error();
      send_str(">AAAX", 1'b0);
      tests++;
      if ({bus.err, bus.busy} !== 2'b10) begin
         fails++;
         $display("FAIL err_set: err/busy=%b required 10", {bus.err, bus.busy});
      end
      send_str("AAAAAAAAAAAAAAAAAAAAAAAA", 1'b0);
      tests++;
      if ({bus.err, bus.out_valid} !== 2'b10) begin
         fails++;
         $display("FAIL err_sticky: err/ov=%b required 10", {bus.err, bus.out_valid});
      end
      sb.push_back({16'h0003, 16'h0001, 16'h0002});
      send(">");
      tests++;
      if ({bus.err, bus.busy} !== 2'b01) begin
         fails++;
         $display("FAIL err_clear: err/busy=%b required 01", {bus.err, bus.busy});
      end
      send_str("AAAAAAATAAAAAAACAAAAAAAG", 1'b0);
      tests++;
      if ({bus.out_valid, bus.err} !== 2'b10) begin
         fails++;
         $display("FAIL err_recover: ov/err=%b required 10", {bus.out_valid, bus.err});
      end
      do_ack();
   endtask

   task automatic test_restart();
      string f2 = "GGGGTTTTACGTACGTTGCATGCA";
      sb.push_back(model_frame(f2));
      send_str(">ACGT>", 1'b0);
      send_str(f2, 1'b0);
      tests++;
      if (bus.out_valid !== 1'b1) begin
         fails++;
         $display("FAIL restart_valid: out_valid=%b required 1", bus.out_valid);
      end
      do_ack();
      repeat (4) @(negedge CLK);
      tests++;
      if (bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL restart_once: out_valid=%b required 0", bus.out_valid);
      end
   endtask

   task automatic test_async_reset();
      string f3 = "TTTTTTTTCCCCGGGGAAAACCCC";
      send_str(">ACGTACGTGGT", 1'b0);
      tests++;
      if (bus.busy !== 1'b1) begin
         fails++;
         $display("FAIL midframe_busy: busy=%b required 1", bus.busy);
      end
      #2 rst = 1'b0;
      #1;
      tests++;
      if ({bus.out_valid, bus.err, bus.busy} !== 3'b000 || {bus.codedA, bus.codedB, bus.codedC} !== 48'h0) begin
         fails++;
         $display("FAIL async_reset: ov/err/busy=%b arrays %h required 000 0", {bus.out_valid, bus.err, bus.busy}, {bus.codedA, bus.codedB, bus.codedC});
      end
      #4 rst = 1'b1;
      @(negedge CLK);
      sb.push_back(model_frame(f3));
      send(">");
      send_str(f3, 1'b1);
      tests++;
      if (bus.out_valid !== 1'b1) begin
         fails++;
         $display("FAIL reset_reload: out_valid=%b required 1", bus.out_valid);
      end
      do_ack();
   endtask

   task automatic test_lowercase();
`ifdef SEQ_LOADER_LOWERCASE_EN
      sb.push_back({3{16'h1B1B}});
      send_str(">acgtacgtacgtacgtacgtacgt", 1'b0);
      tests++;
      if ({bus.out_valid, bus.err} !== 2'b10) begin
         fails++;
         $display("FAIL lower_valid: ov/err=%b required 10", {bus.out_valid, bus.err});
      end
      do_ack();
`else
      send_str(">a", 1'b0);
      tests++;
      if ({bus.err, bus.out_valid} !== 2'b10) begin
         fails++;
         $display("FAIL lower_err: err/ov=%b required 10", {bus.err, bus.out_valid});
      end
      send_str("cgtacgt", 1'b0);
      tests++;
      if ({bus.err, bus.busy} !== 2'b10) begin
         fails++;
         $display("FAIL lower_sticky: err/busy=%b required 10", {bus.err, bus.busy});
      end
`endif
   endtask

   initial begin
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      bus.out_ack  = 1'b0;
      repeat (2) @(negedge CLK);
      rst = 1'b1;
      @(negedge CLK);
      test_reset();
      test_basic_frame();
      test_whitespace_gaps();
      test_error();
      test_restart();
      test_async_reset();
      test_lowercase();
      repeat (3) @(negedge CLK);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d frames outstanding, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/seq_loader.md
Name: seq_loader

Overview:
- Front-end stage that feeds the alignment top level (sequence encoder → DP cube → traceback → verdict).
- Accepts a byte stream of ASCII nucleotide characters framed as three sequences A, B, C.
- Converts each character to a 2-bit code and presents three packed coded arrays with a valid/ack handshake.
- Replaces the string-typed inputs, so the top level can sit behind a byte-serial host link such as a UART or bus bridge.

Parameters:
- LEN, 7, last symbol index; each sequence is exactly LEN+1 bases (matches the top-level LEN).

Ports:
- CLK  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- in_data  in  8  ASCII byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte this cycle
- codedA  out  [0:LEN][0:1]  encoded sequence A, element 0 = first base received
- codedB  out  [0:LEN][0:1]  encoded sequence B
- codedC  out  [0:LEN][0:1]  encoded sequence C
- out_valid  out  1  all three arrays complete and stable
- out_ack  in  1  consumer has taken the arrays
- err  out  1  sticky frame error
- busy  out  1  frame in progress (LOAD state)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; codedA/B/C all 0; out_valid=0; err=0; seq_sel=0; idx=0. in_ready=1 once rst deasserts.
- Transfer: a byte is accepted on a rising CLK edge when in_valid && in_ready. Only accepted bytes have any effect.
- Encoding: 'A'(0x41)=00, 'C'(0x43)=01, 'G'(0x47)=10, 'T'(0x54)=11.
- Whitespace bytes 0x20, 0x0A and 0x0D are accepted and ignored in every state except HOLD.
- Start byte is '>' (0x3E). Every other byte is invalid.
- Counters: idx is $clog2(LEN+1) bits, range 0..LEN. seq_sel is 2 bits, range 0..2.
- State IDLE (in_ready=1, busy=0):
  - '>' → LOAD, with idx=0, seq_sel=0, err cleared.
  - Base character → ignored, stay IDLE. Bases outside a frame are not an error.
  - Invalid byte → ignored.
- State LOAD (in_ready=1, busy=1):
  - Base → writes code into array[seq_sel][idx].
  - idx==LEN → idx=0, seq_sel+1.
  - Base at seq_sel==2, idx==LEN → HOLD on the next edge.
  - '>' → restart the frame (idx=0, seq_sel=0). Already written elements keep their stale values until overwritten.
  - Invalid byte → ERROR.
- State HOLD (in_ready=0, out_valid=1, busy=0):
  - out_valid rises on the edge after the last base is accepted, i.e. 1 cycle of latency.
  - Coded arrays are frozen while in HOLD.
  - out_ack=1 → IDLE on the next edge, out_valid=0. The arrays retain their values.
  - out_ack while out_valid=0 is ignored in all states.
- State ERROR (in_ready=1, err=1, busy=0):
  - All bytes are discarded except '>'.
  - '>' → LOAD with err cleared on the same edge.
- Coded arrays change only in LOAD. Consumers must sample them only while out_valid=1.
- Reset mid-frame or in HOLD aborts immediately and returns to the reset values. A partial frame is never presented.
- Simultaneous events:
  - The last base and in_valid on the following cycle cannot collide, because in_ready is already low in HOLD.
  - out_ack in HOLD together with in_valid: the byte is not accepted that cycle (in_ready=0).

Optional Feature:
- Macro: SEQ_LOADER_LOWERCASE_EN
- Defined: 'a','c','g','t' (0x61, 0x63, 0x67, 0x74) are accepted as bases with the same codes as upper case.
- Undefined: lower-case bytes are invalid. In LOAD they cause ERROR; in IDLE they are ignored.

Test Plan:
1. Reset, then send ">CTCAGTATCGTCATTACCCTGGTC" with in_valid held high → out_valid=1 one cycle after the final 'C'.
   - codedA = 01,11,01,00,10,11,00,11
   - codedB = 01,10,11,01,00,11,11,00
   - codedC = 01,01,01,11,10,10,11,01
   - in_ready=0 until out_ack, then IDLE with out_valid=0 and arrays unchanged.
2. Same frame with "\r\n" after each 8-char sequence and random in_valid gaps → identical arrays. No byte is lost while in_ready=1.
3. ">AAAXAAA" → err=1 after 'X'.
   - Further bases are ignored and out_valid stays 0.
   - Then ">AAAAAAATAAAAAAACAAAAAAAG" → err=0 and out_valid=1 with last codes 11/01/10 for A/B/C.
4. ">ACGT" followed by ">" and a full valid frame → arrays reflect only the second frame, out_valid=1 exactly once.
5. Assert rst=0 for one cycle midway through sequence B, asynchronous to CLK → all outputs return to 0 immediately, state IDLE. A new full frame then loads correctly.
6. ">acgtacgt..." (24 bases):
   - With SEQ_LOADER_LOWERCASE_EN → codes 00,01,10,11 repeating, out_valid=1.
   - Without it → err=1 after the first 'a'.
